// File: rtl/button_debounce_if.sv
// button_debounce_if: sample-strobe and raw pin toward the debouncer, cleaned
// level and event pulses back toward the game-control FSM.
interface button_debounce_if;
  logic clk_spori;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  modport master (
    output clk_spori,
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  clk_spori,
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: debounces one push-button pin. The pin is sampled once per
// rising edge of clk_spori (used as a data strobe, not a clock); a level change
// is accepted after STABLE_TICKS consecutive matching samples. Produces a clean
// level plus registered one-clk press/release pulses.
// Optional long-press pulse: define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 200,
  parameter int unsigned CNT_W        = 8,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  button_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_TICKS);

  if (STABLE_TICKS < 1 ||
      CNT_W < $clog2(STABLE_TICKS + 1) ||
      CNT_W < $clog2(LONG_TICKS + 1)) begin : g_bad_params
    $error("button_debounce: STABLE_TICKS must be >=1 and CNT_W must hold max(STABLE_TICKS, LONG_TICKS)");
  end

  logic             sync1_q;
  logic             sync2_q;
  logic             spori_d_q;
  logic             sample;
  logic             tick;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Pin synchronizer and strobe edge-detect register; reset to the idle pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      spori_d_q <= 1'b0;
    end else begin
      sync1_q   <= bus.btn_in;
      sync2_q   <= sync1_q;
      spori_d_q <= bus.clk_spori;
    end
  end

  assign sample  = sync2_q ^ ACTIVE_LOW;
  assign tick    = bus.clk_spori & ~spori_d_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Debounce FSM state, counter and registered event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: advances only on sample ticks; pulses default low
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        RELEASED: begin
          if (sample) begin
            if (STABLE_TICKS == 1) begin
              state_d = PRESSED;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = WAIT_PRESS;
              cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        WAIT_PRESS: begin
          if (!sample) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_CNT) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!sample) begin
            if (STABLE_TICKS == 1) begin
              state_d   = RELEASED;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = WAIT_RELEASE;
              cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        WAIT_RELEASE: begin
          if (sample) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_CNT) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Level is 1 for the whole pressed half of the FSM, so it flips in the same
  // cycle the registered press/release pulse appears.
  assign bus.btn_level   = (state_q == PRESSED) || (state_q == WAIT_RELEASE);
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_TICKS);

  logic [CNT_W-1:0] long_cnt_q;
  logic [CNT_W-1:0] long_cnt_d;
  logic             long_q;
  logic             long_d;

  // Long-press counter and registered pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  // Counts ticks spent pressed; stops at LONG_TICKS so the pulse fires once.
  // press_d marks entry to PRESSED from a press, so a bounce back from
  // WAIT_RELEASE keeps the count.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (tick && (state_q == PRESSED || state_q == WAIT_RELEASE) &&
        (long_cnt_q < LONG_CNT)) begin
      long_cnt_d = long_cnt_q + 1'b1;
      long_d     = (long_cnt_q == LONG_CNT - 1'b1);
    end
    if (press_d) begin
      long_cnt_d = '0;
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = 1'b0;
`endif

endmodule
